// File: rtl/move_segment_queue_if.sv
// Segment bus between SPI decoder (producer), segment queue and DDA (consumer).
// The master side is the producer/consumer pair; the slave side is the queue.
interface move_segment_queue_if #(
    parameter int unsigned WORD_W = 64
);
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_dir;
    logic [WORD_W-1:0] wr_duration;
    logic [WORD_W-1:0] wr_increment;
    logic [WORD_W-1:0] wr_incinc;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_dir;
    logic [WORD_W-1:0] rd_duration;
    logic [WORD_W-1:0] rd_increment;
    logic [WORD_W-1:0] rd_incinc;

    modport master (
        output wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc, rd_ready,
        input  wr_ready, rd_valid, rd_dir, rd_duration, rd_increment, rd_incinc
    );

    modport slave (
        input  wr_valid, wr_dir, wr_duration, wr_increment, wr_incinc, rd_ready,
        output wr_ready, rd_valid, rd_dir, rd_duration, rd_increment, rd_incinc
    );
endinterface

// File: rtl/move_segment_queue.sv
// Circular FWFT queue of coordinated-move segments between the SPI decoder and the DDA.
// Pointers carry a wrap bit so full/empty need no separate occupancy register.
module move_segment_queue #(
    parameter int unsigned DEPTH_BITS = 2,
    parameter int unsigned WORD_W     = 64
) (
    input  logic                  CLK,
    input  logic                  resetn,
    move_segment_queue_if.slave   seg,
    input  logic                  flush,
    input  logic                  clear_errors,
    output logic [DEPTH_BITS:0]   count,
    output logic                  overflow,
    output logic                  zero_dur_err,
    output logic [15:0]           pop_count
);
    localparam int unsigned DEPTH = 2 ** DEPTH_BITS;
    localparam int unsigned PTR_W = DEPTH_BITS + 1;

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  overflow_q, overflow_d;
    logic                  zero_dur_q, zero_dur_d;
    logic [15:0]           pop_cnt_q, pop_cnt_d;

    logic                  mem_dir [DEPTH];
    logic [WORD_W-1:0]     mem_duration [DEPTH];
    logic [WORD_W-1:0]     mem_increment [DEPTH];
    logic [WORD_W-1:0]     mem_incinc [DEPTH];

    logic [DEPTH_BITS-1:0] wr_idx, rd_idx;
    logic                  empty, full, wr_hs, zero_dur, push, pop;

    assign wr_idx   = wr_ptr_q[DEPTH_BITS-1:0];
    assign rd_idx   = rd_ptr_q[DEPTH_BITS-1:0];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_idx == rd_idx) && (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);
    assign wr_hs    = seg.wr_valid && !full;
    assign zero_dur = (seg.wr_duration == '0);
    // Flush overrides any handshake in the same cycle.
    assign push     = wr_hs && !zero_dur && !flush;
    assign pop      = !empty && seg.rd_ready && !flush;

    // Next-state for pointers, pop counter and sticky errors.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pop_cnt_d  = pop_cnt_q;
        overflow_d = overflow_q;
        zero_dur_d = zero_dur_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                pop_cnt_d = pop_cnt_q + 16'(1);
            end
        end

        if (clear_errors) begin
            overflow_d = 1'b0;
            zero_dur_d = 1'b0;
        end
        // A fresh error in the clearing cycle still wins; a flush leaves flags alone.
        if (!flush && seg.wr_valid && full) begin
            overflow_d = 1'b1;
        end
        if (!flush && wr_hs && zero_dur) begin
            zero_dur_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pop_cnt_q  <= '0;
            overflow_q <= 1'b0;
            zero_dur_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pop_cnt_q  <= pop_cnt_d;
            overflow_q <= overflow_d;
            zero_dur_q <= zero_dur_d;
        end
    end

    // Segment storage; contents are meaningless until written, so no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_dir[wr_idx]       <= seg.wr_dir;
            mem_duration[wr_idx]  <= seg.wr_duration;
            mem_increment[wr_idx] <= seg.wr_increment;
            mem_incinc[wr_idx]    <= seg.wr_incinc;
        end
    end

    assign seg.wr_ready     = !full;
    assign seg.rd_valid     = !empty;
    assign seg.rd_dir       = mem_dir[rd_idx];
    assign seg.rd_duration  = mem_duration[rd_idx];
    assign seg.rd_increment = mem_increment[rd_idx];
    assign seg.rd_incinc    = mem_incinc[rd_idx];

    assign count        = wr_ptr_q - rd_ptr_q;
    assign overflow     = overflow_q;
    assign zero_dur_err = zero_dur_q;
    assign pop_count    = pop_cnt_q;
endmodule

// File: tb/tb_move_segment_queue.sv
// Bench for move_segment_queue: directed scenarios plus random traffic, with a
// queue-based reference model and a negedge monitor acting as scoreboard.
module tb_move_segment_queue;
    localparam int unsigned DB = 2;
    localparam int unsigned W  = 64;
    localparam int          CAP = 4;

    typedef struct {
        logic         dir;
        logic [W-1:0] dur;
        logic [W-1:0] inc;
        logic [W-1:0] incinc;
    } seg_t;

    logic          CLK;
    logic          resetn;
    logic          flush;
    logic          clear_errors;
    logic [DB:0]   count;
    logic          overflow;
    logic          zero_dur_err;
    logic [15:0]   pop_count;

    move_segment_queue_if #(.WORD_W(W)) bus ();

    move_segment_queue #(.DEPTH_BITS(DB), .WORD_W(W)) dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .seg          (bus),
        .flush        (flush),
        .clear_errors (clear_errors),
        .count        (count),
        .overflow     (overflow),
        .zero_dur_err (zero_dur_err),
        .pop_count    (pop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    seg_t        exp_q[$];
    logic        m_ovf;
    logic        m_zd;
    logic [15:0] m_pc;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid     = 1'b0;
        bus.wr_dir       = 1'b0;
        bus.wr_duration  = '0;
        bus.wr_increment = '0;
        bus.wr_incinc    = '0;
        bus.rd_ready     = 1'b0;
        flush            = 1'b0;
        clear_errors     = 1'b0;
    endtask

    task automatic offer(input logic dir, input logic [W-1:0] dur, input logic [W-1:0] inc,
                         input logic [W-1:0] incinc);
        bus.wr_valid     = 1'b1;
        bus.wr_dir       = dir;
        bus.wr_duration  = dur;
        bus.wr_increment = inc;
        bus.wr_incinc    = incinc;
    endtask

    // Monitor/scoreboard: compare what the DUT shows, then apply the upcoming edge to the model.
    initial begin
        seg_t s;
        bit   m_full, m_empty;
        exp_q.delete();
        m_ovf = 1'b0;
        m_zd  = 1'b0;
        m_pc  = '0;
        forever begin
            @(negedge CLK);
            if (!resetn) begin
                exp_q.delete();
                m_ovf = 1'b0;
                m_zd  = 1'b0;
                m_pc  = '0;
            end
            check("mon_count", 64'(count), 64'(exp_q.size()));
            check("mon_wr_ready", 64'(bus.wr_ready), 64'(exp_q.size() != CAP));
            check("mon_rd_valid", 64'(bus.rd_valid), 64'(exp_q.size() != 0));
            check("mon_overflow", 64'(overflow), 64'(m_ovf));
            check("mon_zero_dur_err", 64'(zero_dur_err), 64'(m_zd));
            check("mon_pop_count", 64'(pop_count), 64'(m_pc));
            if (bus.rd_valid && exp_q.size() > 0) begin
                check("head_dir", 64'(bus.rd_dir), 64'(exp_q[0].dir));
                check("head_duration", bus.rd_duration, exp_q[0].dur);
                check("head_increment", bus.rd_increment, exp_q[0].inc);
                check("head_incinc", bus.rd_incinc, exp_q[0].incinc);
            end
            if (resetn) begin
                m_full  = (exp_q.size() == CAP);
                m_empty = (exp_q.size() == 0);
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (!m_empty && bus.rd_ready) begin
                        void'(exp_q.pop_front());
                        m_pc = m_pc + 16'd1;
                    end
                    if (bus.wr_valid && !m_full && bus.wr_duration != 0) begin
                        s.dir    = bus.wr_dir;
                        s.dur    = bus.wr_duration;
                        s.inc    = bus.wr_increment;
                        s.incinc = bus.wr_incinc;
                        exp_q.push_back(s);
                    end
                end
                if (clear_errors) begin
                    m_ovf = 1'b0;
                    m_zd  = 1'b0;
                end
                if (!flush && bus.wr_valid && m_full) m_ovf = 1'b1;
                if (!flush && bus.wr_valid && !m_full && bus.wr_duration == 0) m_zd = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed and random stimulus
    initial begin
        idle();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        step();
        step();
        check("reset_count", 64'(count), 64'd0);
        check("reset_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("reset_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_zero_dur", 64'(zero_dur_err), 64'd0);
        check("reset_pop_count", 64'(pop_count), 64'd0);
        resetn = 1'b1;
        step();

        // Single segment push then pop
        offer(1'b1, 64'd100, 64'h10, '1);
        step();
        idle();
        check("single_rd_valid", 64'(bus.rd_valid), 64'd1);
        check("single_duration", bus.rd_duration, 64'd100);
        check("single_incinc", bus.rd_incinc, 64'hFFFF_FFFF_FFFF_FFFF);
        check("single_count", 64'(count), 64'd1);
        bus.rd_ready = 1'b1;
        step();
        idle();
        check("single_pop_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("single_pop_count", 64'(pop_count), 64'd1);

        // Fill, overflow, drain in order
        for (int i = 1; i <= 4; i++) begin
            offer(1'b0, 64'(i), 64'(i * 3), 64'(i * 5));
            step();
        end
        check("fill_count", 64'(count), 64'd4);
        check("fill_wr_ready", 64'(bus.wr_ready), 64'd0);
        offer(1'b1, 64'd5, 64'd0, 64'd0);
        step();
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_count", 64'(count), 64'd4);
        idle();
        bus.rd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", bus.rd_duration, 64'(i));
            step();
            if (i == 1) check("drain_wr_ready", 64'(bus.wr_ready), 64'd1);
        end
        check("drain_count", 64'(count), 64'd0);
        idle();
        clear_errors = 1'b1;
        step();
        idle();
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Steady stream at occupancy 2 across pointer wrap
        offer(1'b0, 64'd10, 64'd0, 64'd0);
        step();
        offer(1'b1, 64'd11, 64'd0, 64'd0);
        step();
        bus.rd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer(1'(k), 64'(12 + k), 64'(k), 64'(-k));
            check("stream_head", bus.rd_duration, 64'(10 + k));
            step();
            check("stream_count", 64'(count), 64'd2);
        end
        bus.wr_valid = 1'b0;
        check("stream_tail0", bus.rd_duration, 64'd20);
        step();
        check("stream_tail1", bus.rd_duration, 64'd21);
        step();
        idle();
        check("stream_empty", 64'(bus.rd_valid), 64'd0);

        // Zero-duration rejection and error clear
        offer(1'b1, 64'd0, 64'd7, 64'd7);
        step();
        check("zd_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("zd_count", 64'(count), 64'd0);
        check("zd_flag", 64'(zero_dur_err), 64'd1);
        idle();
        clear_errors = 1'b1;
        step();
        idle();
        check("zd_cleared", 64'(zero_dur_err), 64'd0);

        // Flush beats simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            offer(1'b0, 64'(20 + i), 64'd1, 64'd2);
            step();
        end
        check("preflush_count", 64'(count), 64'd3);
        offer(1'b1, 64'd23, 64'd1, 64'd2);
        bus.rd_ready = 1'b1;
        flush = 1'b1;
        step();
        idle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("flush_pop_count", 64'(pop_count), 64'd17);
        step();
        check("flush_not_stored", 64'(bus.rd_valid), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.wr_valid     = ($urandom_range(0, 9) < 7);
            bus.wr_dir       = 1'($urandom);
            bus.wr_duration  = ($urandom_range(0, 9) == 0) ? 64'd0 : {$urandom, $urandom};
            bus.wr_increment = {$urandom, $urandom};
            bus.wr_incinc    = {$urandom, $urandom};
            bus.rd_ready     = 1'($urandom);
            clear_errors     = ($urandom_range(0, 19) == 0);
            flush            = 1'b0;
            if ($urandom_range(0, 29) == 0) begin
                flush        = 1'b1;
                bus.wr_valid = 1'b0;
                clear_errors = 1'b0;
            end
            step();
        end
        idle();

        // pop_count wrap after 65537 pops from a fresh reset
        resetn = 1'b0;
        step();
        step();
        resetn = 1'b1;
        step();
        offer(1'b0, 64'd1, 64'd0, 64'd0);
        step();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            offer(1'(i), 64'(1 + (i & 255)), 64'(i), 64'(i));
            step();
        end
        idle();
        check("wrap_pop_count", 64'(pop_count), 64'd1);
        check("wrap_count", 64'(count), 64'd1);

        // Reset in the middle of a push with errors set
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 64'(30 + i), 64'd0, 64'd0);
            step();
        end
        check("pre_reset_ovf", 64'(overflow), 64'd1);
        offer(1'b1, 64'd40, 64'd0, 64'd0);
        resetn = 1'b0;
        #1;
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_overflow", 64'(overflow), 64'd0);
        check("midrst_zero_dur", 64'(zero_dur_err), 64'd0);
        check("midrst_wr_ready", 64'(bus.wr_ready), 64'd1);
        check("midrst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check("midrst_pop_count", 64'(pop_count), 64'd0);
        step();
        idle();
        step();
        resetn = 1'b1;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/move_segment_queue.md
Name: move_segment_queue

Overview:
- Buffers coordinated-move segments between the SPI message decoder (producer) and the DDA step-timing engine (consumer).
- Each segment carries: direction, duration in DDA ticks, signed increment, signed increment-increment.
- Single-clock circular FIFO with valid/ready on both sides, first-word-fall-through head, flush and sticky error flags.
- Replaces the ad-hoc stepready/stepfinished toggle handshake between decoder and DDA.

Parameters:
- DEPTH_BITS, 2, log2 of queue depth (depth = 2**DEPTH_BITS = 4 segments).
- WORD_W, 64, width of duration, increment and increment-increment fields.

Ports:
- CLK  in  1  system clock (16 MHz).
- resetn  in  1  asynchronous active-low reset.
- wr_valid  in  1  producer offers a segment.
- wr_ready  out  1  queue can accept; equals !full.
- wr_dir  in  1  segment direction.
- wr_duration  in  WORD_W  segment length in DDA ticks, unsigned.
- wr_increment  in  WORD_W  signed start increment.
- wr_incinc  in  WORD_W  signed increment-increment.
- rd_valid  out  1  head segment available; equals !empty.
- rd_ready  in  1  consumer takes the head segment.
- rd_dir  out  1  head direction.
- rd_duration  out  WORD_W  head duration.
- rd_increment  out  WORD_W  head increment.
- rd_incinc  out  WORD_W  head increment-increment.
- flush  in  1  synchronous queue clear.
- clear_errors  in  1  clears sticky error flags.
- count  out  DEPTH_BITS+1  occupancy, 0..2**DEPTH_BITS.
- overflow  out  1  sticky: wr_valid asserted while full.
- zero_dur_err  out  1  sticky: zero-duration segment rejected.
- pop_count  out  16  wrapping count of segments handed to the consumer.

Behaviour:
- Reset (resetn low, async): wr_ptr=0, rd_ptr=0, count=0, overflow=0, zero_dur_err=0, pop_count=0.
  - Hence rd_valid=0 and wr_ready=1.
  - Storage array is not reset; rd_* data is don't-care while rd_valid=0.
- Pointers are DEPTH_BITS+1 wide (wrap bit).
  - empty = (wr_ptr == rd_ptr).
  - full = (index bits equal AND wrap bits differ).
  - count = wr_ptr - rd_ptr, modulo 2**(DEPTH_BITS+1).
- Push: on a CLK edge with wr_valid & wr_ready & (wr_duration != 0).
  - Writes all four fields at wr_ptr index and increments wr_ptr.
- Zero-duration write: wr_valid & wr_ready & wr_duration==0.
  - Handshake completes (producer sees acceptance).
  - Nothing is stored; zero_dur_err set to 1 next cycle.
- Overflow: wr_valid & full sets overflow to 1 next cycle.
  - Segment is not stored; producer must hold wr_valid until wr_ready.
- Pop: on a CLK edge with rd_valid & rd_ready.
  - rd_ptr increments and pop_count increments (16-bit wrap, 0xFFFF -> 0x0000).
- rd_ready while empty: no effect, not an error.
- FWFT: rd_* are driven combinationally from the storage entry at rd_ptr.
  - A segment pushed at edge N is visible with rd_valid=1 after edge N.
  - Push-to-pop latency is 1 cycle.
- No combinational path from rd_ready to wr_ready, or from wr_valid to rd_valid.
- Simultaneous push and pop (neither full nor empty): both happen; count unchanged.
- Full with pop: only the pop occurs (wr_ready was 0); wr_ready=1 after the edge.
- Empty with push: only the push occurs; rd_valid=1 after the edge.
- flush=1 at an edge:
  - rd_ptr <= wr_ptr; count=0.
  - Any push or pop in the same cycle is ignored; pop_count unchanged.
  - Error flags unchanged.
- clear_errors=1 at an edge: both sticky flags <= 0.
  - If a new error condition occurs in the same cycle, the set wins.
- Reset mid-operation: everything returns to the reset values immediately; queued segments are lost.
- Head data is stable while rd_valid=1 and no pop occurs, even if pushes continue.

Test Plan:
- Reset, push {dir=1, dur=100, inc=0x10, incinc=-1} -> next cycle rd_valid=1, rd_duration=100, rd_incinc=0xFFFF_FFFF_FFFF_FFFF, count=1; pop -> rd_valid=0, pop_count=1.
- Push 4 segments with durations 1..4, rd_ready=0 -> count=4, wr_ready=0. Hold wr_valid one more cycle -> overflow=1, count stays 4. Pop 4 -> durations come out 1,2,3,4 in order.
- Fill to 2 entries, then push+pop every cycle for 10 cycles -> count stays 2, output order preserved, pointers wrap cleanly past depth.
- Push dur=0 -> wr_ready stays 1, count=0, zero_dur_err=1. Then clear_errors -> zero_dur_err=0.
- 3 queued entries, assert flush together with wr_valid and rd_ready -> count=0, rd_valid=0, pop_count unchanged, new segment not stored.
- Perform 65,537 pops -> pop_count wraps to 1. Assert resetn low mid-push -> count=0, all flags 0, wr_ready=1.
